// File: rtl/axis_frame_len_stats.sv
// Passive AXI-Stream frame length monitor (tkeep popcount); define AXIS_FRAME_LEN_MINMAX_EN for len_min/len_max tracking.
// Results appear one cycle after the tlast beat; snoop only, exerts no backpressure.
module axis_frame_len_stats #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int MIN_LEN     = 1,
    parameter int MAX_LEN     = 1518
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
    input  logic                   monitor_axis_tvalid,
    input  logic                   monitor_axis_tready,
    input  logic                   monitor_axis_tlast,
    input  logic                   stat_clear,
    output logic [LEN_WIDTH-1:0]   frame_len,
    output logic                   frame_len_valid,
    output logic                   frame_len_sat,
    output logic                   frame_runt,
    output logic                   frame_oversize,
    output logic                   in_frame,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [LEN_WIDTH-1:0]   len_min,
    output logic [LEN_WIDTH-1:0]   len_max
);
    localparam int INC_W = $clog2(KEEP_WIDTH + 1);
    localparam int SUM_W = LEN_WIDTH + INC_W;
    localparam int CMP_W = (LEN_WIDTH > 32) ? LEN_WIDTH : 32;

    logic [INC_W-1:0]     keep_cnt;
    logic [INC_W-1:0]     inc;
    logic [SUM_W-1:0]     sum;
    logic                 overflow;
    logic [LEN_WIDTH-1:0] sat_len;
    logic                 sat_now;
    logic [CMP_W-1:0]     len_ext;
    logic                 beat;
    logic                 done;

    logic [LEN_WIDTH-1:0]   acc_q, acc_d;
    logic                   sat_acc_q, sat_acc_d;
    logic                   in_frame_q, in_frame_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   vld_q, vld_d;
    logic                   sat_q, sat_d;
    logic                   runt_q, runt_d;
    logic                   over_q, over_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + INC_W'(monitor_axis_tkeep[i]);
        end
    end

    assign inc      = (KEEP_ENABLE != 0) ? keep_cnt : INC_W'(1);
    assign beat     = monitor_axis_tvalid & monitor_axis_tready;
    assign done     = beat & monitor_axis_tlast;
    // Extra headroom bits catch the carry; any set bit above LEN_WIDTH means clamp.
    assign sum      = SUM_W'(acc_q) + SUM_W'(inc);
    assign overflow = |sum[SUM_W-1:LEN_WIDTH];
    assign sat_len  = overflow ? '1 : sum[LEN_WIDTH-1:0];
    assign sat_now  = sat_acc_q | overflow;
    assign len_ext  = CMP_W'(sat_len);

    always_comb begin
        acc_d      = acc_q;
        sat_acc_d  = sat_acc_q;
        in_frame_d = in_frame_q;
        len_d      = len_q;
        vld_d      = done;
        sat_d      = sat_q;
        runt_d     = runt_q;
        over_d     = over_q;
        count_d    = count_q;
        if (beat) begin
            if (monitor_axis_tlast) begin
                acc_d      = '0;
                sat_acc_d  = 1'b0;
                in_frame_d = 1'b0;
                len_d      = sat_len;
                sat_d      = sat_now;
                runt_d     = len_ext < CMP_W'(MIN_LEN);
                over_d     = len_ext > CMP_W'(MAX_LEN);
            end else begin
                acc_d      = sat_len;
                sat_acc_d  = sat_now;
                in_frame_d = 1'b1;
            end
        end
        // Clear takes priority over a coincident completion.
        if (stat_clear) begin
            count_d = '0;
        end else if (done) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            sat_acc_q  <= 1'b0;
            in_frame_q <= 1'b0;
            len_q      <= '0;
            vld_q      <= 1'b0;
            sat_q      <= 1'b0;
            runt_q     <= 1'b0;
            over_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            acc_q      <= acc_d;
            sat_acc_q  <= sat_acc_d;
            in_frame_q <= in_frame_d;
            len_q      <= len_d;
            vld_q      <= vld_d;
            sat_q      <= sat_d;
            runt_q     <= runt_d;
            over_q     <= over_d;
            count_q    <= count_d;
        end
    end

    assign frame_len       = len_q;
    assign frame_len_valid = vld_q;
    assign frame_len_sat   = sat_q;
    assign frame_runt      = runt_q;
    assign frame_oversize  = over_q;
    assign in_frame        = in_frame_q;
    assign frame_count     = count_q;

`ifdef AXIS_FRAME_LEN_MINMAX_EN
    logic [LEN_WIDTH-1:0] min_q, min_d;
    logic [LEN_WIDTH-1:0] max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (stat_clear) begin
            min_d = '1;
            max_d = '0;
        end else if (done) begin
            if (sat_len < min_q) min_d = sat_len;
            if (sat_len > max_q) max_d = sat_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign len_min = min_q;
    assign len_max = max_q;
`else
    assign len_min = '1;
    assign len_max = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed plus randomized stimulus against a frame-level reference model (total bytes per frame, clamped at completion).
module tb_axis_frame_len_stats;
    localparam int DW      = 32;
    localparam int KW      = 4;
    localparam int LW      = 6;
    localparam int CW      = 8;
    localparam int MINL    = 4;
    localparam int MAXL    = 40;
    localparam int LEN_MAX = (1 << LW) - 1;
    localparam int CNT_MOD = (1 << CW);
`ifdef AXIS_FRAME_LEN_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] tkeep = '0;
    logic          tvalid = 1'b0;
    logic          tready = 1'b0;
    logic          tlast = 1'b0;
    logic          stat_clear = 1'b0;
    logic [LW-1:0] frame_len;
    logic          frame_len_valid;
    logic          frame_len_sat;
    logic          frame_runt;
    logic          frame_oversize;
    logic          in_frame;
    logic [CW-1:0] frame_count;
    logic [LW-1:0] len_min;
    logic [LW-1:0] len_max;

    axis_frame_len_stats #(
        .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .LEN_WIDTH(LW),
        .COUNT_WIDTH(CW), .MIN_LEN(MINL), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
        .stat_clear(stat_clear),
        .frame_len(frame_len), .frame_len_valid(frame_len_valid),
        .frame_len_sat(frame_len_sat), .frame_runt(frame_runt),
        .frame_oversize(frame_oversize), .in_frame(in_frame),
        .frame_count(frame_count), .len_min(len_min), .len_max(len_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the open frame as an unbounded integer, clamped only when the frame ends.
    int m_bytes, m_len, m_cnt, m_min, m_max;
    bit m_in, m_vld, m_sat, m_runt, m_over;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bytes = 0; m_len = 0; m_cnt = 0; m_min = LEN_MAX; m_max = 0;
        m_in = 0; m_vld = 0; m_sat = 0; m_runt = 0; m_over = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},    64'(frame_len_valid), 64'(m_vld));
        check({tag, ".len"},      64'(frame_len),       64'(m_len));
        check({tag, ".sat"},      64'(frame_len_sat),   64'(m_sat));
        check({tag, ".runt"},     64'(frame_runt),      64'(m_runt));
        check({tag, ".oversize"}, 64'(frame_oversize),  64'(m_over));
        check({tag, ".in_frame"}, 64'(in_frame),        64'(m_in));
        check({tag, ".count"},    64'(frame_count),     64'(m_cnt));
        check({tag, ".len_min"},  64'(len_min),         64'(MINMAX ? m_min : LEN_MAX));
        check({tag, ".len_max"},  64'(len_max),         64'(MINMAX ? m_max : 0));
    endtask

    task automatic step(input string tag, input logic [KW-1:0] k, input bit v, input bit r,
                        input bit l, input bit clr);
        tkeep = k; tvalid = v; tready = r; tlast = l; stat_clear = clr;
        @(posedge clk);
        #1;
        m_vld = 0;
        if (v && r) begin
            m_bytes += $countones(k);
            if (l) begin
                m_sat  = m_bytes > LEN_MAX;
                m_len  = m_sat ? LEN_MAX : m_bytes;
                m_runt = m_len < MINL;
                m_over = m_len > MAXL;
                m_vld  = 1;
                m_bytes = 0;
                m_in   = 0;
                if (!clr) begin
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                    if (m_len < m_min) m_min = m_len;
                    if (m_len > m_max) m_max = m_len;
                end
            end else begin
                m_in = 1;
            end
        end
        if (clr) begin
            m_cnt = 0; m_min = LEN_MAX; m_max = 0;
        end
        tvalid = 0; tready = 0; tlast = 0; stat_clear = 0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        #8 rst_n = 1'b1;

        // Single-byte frames: 2 bytes, then 1 byte on the very next cycle.
        step("b2a", 4'h1, 1, 1, 0, 0);
        step("b2b", 4'h1, 1, 1, 1, 0);
        step("b1",  4'h1, 1, 1, 1, 0);
        check("b1.strobe_len", 64'(frame_len), 64'd1);

        // Keep-based counting with an unaccepted beat in the middle.
        step("k0",    4'hF, 1, 1, 0, 0);
        step("stall", 4'hF, 1, 0, 0, 0);
        step("k1",    4'hF, 1, 1, 0, 0);
        step("k2",    4'h7, 1, 1, 1, 0);
        check("keep.len11", 64'(frame_len), 64'd11);

        // 80 bytes into a 6-bit counter: clamps at 63, oversize.
        for (int i = 0; i < 20; i++) step("sat", 4'hF, 1, 1, i == 19, 0);
        check("sat.flag", 64'(frame_len_sat), 64'd1);

        // Runt then just-above-threshold frame, then an empty-keep frame.
        step("r0", 4'h1, 1, 1, 0, 0);
        step("r1", 4'h1, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) step("nr", 4'h1, 1, 1, i == 4, 0);
        step("zero", 4'h0, 1, 1, 1, 0);
        // Exactly MAX_LEN is not oversize.
        for (int i = 0; i < 10; i++) step("max40", 4'hF, 1, 1, i == 9, 0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 3; i++) step("pre_rst", 4'h3, 1, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #10 rst_n = 1'b1;
        step("post0", 4'h1, 1, 1, 0, 0);
        step("post1", 4'h1, 1, 1, 1, 0);

        // Bring count to 5, then clear coincident with a completion.
        for (int i = 0; i < 4; i++) step("to5", 4'h1, 1, 1, 1, 0);
        step("clr_last", 4'h3, 1, 1, 1, 1);
        // Clear mid-frame leaves the accumulator alone.
        step("cm0", 4'hF, 1, 1, 0, 0);
        step("cm1", 4'hF, 1, 1, 0, 1);
        step("cm2", 4'h1, 1, 1, 1, 0);

        // Enough back-to-back frames to wrap the 8-bit frame counter.
        for (int i = 0; i < 260; i++) step("wrap", 4'($urandom_range(0, 15)), 1, 1, 1, 0);

        for (int i = 0; i < 600; i++) begin
            step("rand", 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_frame_len_stats.md
Name: axis_frame_len_stats

Overview:
Parametrised successor to the single-counter frame length monitor. It passively snoops an AXI-Stream interface and counts bytes per frame using a tkeep popcount. For each completed frame it reports the length, a saturation flag and runt/oversize classification. It also keeps a running frame counter and optional min/max length statistics for the status/CSR block.

Parameters:
DATA_WIDTH, 8, tdata width in bits (tdata itself is not observed)
KEEP_ENABLE, (DATA_WIDTH>8), 1: count popcount(tkeep) bytes per beat; 0: count 1 per beat
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
LEN_WIDTH, 16, frame length counter width (bytes)
COUNT_WIDTH, 32, completed-frame counter width
MIN_LEN, 1, lengths below this are runts
MAX_LEN, 1518, lengths above this are oversize

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
monitor_axis_tkeep  in  KEEP_WIDTH  byte enables of the observed beat
monitor_axis_tvalid  in  1  observed tvalid
monitor_axis_tready  in  1  observed tready
monitor_axis_tlast  in  1  observed tlast
stat_clear  in  1  synchronous clear of frame_count and min/max
frame_len  out  LEN_WIDTH  length of the last completed frame, in bytes
frame_len_valid  out  1  one-cycle strobe: frame_len and flags are updated
frame_len_sat  out  1  last frame saturated the counter
frame_runt  out  1  last frame length < MIN_LEN
frame_oversize  out  1  last frame length > MAX_LEN
in_frame  out  1  at least one beat of the current frame has been accepted
frame_count  out  COUNT_WIDTH  number of completed frames, wraps
len_min  out  LEN_WIDTH  smallest frame length since clear (optional)
len_max  out  LEN_WIDTH  largest frame length since clear (optional)

Behaviour:
- Beat = tvalid && tready. No beat means no state change, except stat_clear.
- inc = popcount(tkeep) if KEEP_ENABLE, else 1. With KEEP_ENABLE, tkeep==0 adds 0 but still counts as a beat (sets in_frame, can end a frame).
- acc accumulates per beat. The sum acc+inc saturates at 2^LEN_WIDTH-1 and sets a sticky sat bit for the frame.
- Beat with tlast:
  - at the next edge, frame_len = saturated sum, frame_len_valid = 1 for one cycle;
  - frame_len_sat, frame_runt and frame_oversize are computed from the same sum;
  - acc, the sticky sat bit and in_frame clear.
- Latency: frame_len_valid rises on the edge that samples the tlast beat, i.e. it is visible in the following cycle.
- Back-to-back single-beat tlast frames give a strobe every cycle with no gaps. Each frame starts from 0.
- frame_len and the flags hold their value until the next completion. frame_len_valid is low otherwise.
- frame_count increments by 1 on each completion and wraps from all-ones to 0.
- Outputs while rst_n is low (applied immediately, asynchronously): all outputs 0, except len_min = all-ones. acc = 0, in_frame = 0.
- Reset mid-frame discards the partial frame; no strobe is generated for it.
- stat_clear:
  - next edge: frame_count = 0, len_min = all-ones, len_max = 0;
  - if a completion occurs in the same cycle, clear wins: that frame is not counted and not folded into min/max;
  - frame_len, frame_len_valid and the flags are still produced normally;
  - the accumulator is unaffected.
- Runt/oversize comparisons use the saturated value, compared against MIN_LEN and MAX_LEN in full width.

Optional Feature:
AXIS_FRAME_LEN_MINMAX_EN.
- Defined: len_min and len_max update on each counted completion:
  - len_min = min(len_min, len), len_max = max(len_max, len);
  - both use the saturated length.
- Undefined: min/max logic is omitted, and len_min and len_max are tied to constant all-ones and 0 respectively.
- The port list is identical in both builds.

Test Plan:
- DATA_WIDTH=8: beats {tkeep=1}, {tkeep=1, tlast}, then {tkeep=1, tlast} -> strobes with frame_len=2 then frame_len=1 on consecutive cycles; frame_count=2; len_min=1, len_max=2 (MINMAX_EN).
- DATA_WIDTH=32: beats tkeep=4'hF, 4'hF, 4'h7+tlast, with a tvalid-only cycle (tready=0) inserted -> frame_len=11; the stalled cycle adds nothing.
- LEN_WIDTH=4: 20 single-byte beats, last with tlast -> frame_len=15, frame_len_sat=1, frame_oversize by MAX_LEN=10 is 1.
- MIN_LEN=4: 2-beat frame -> frame_runt=1, frame_len=2. Next frame of 5 beats -> frame_runt=0.
- rst_n pulsed low after 3 beats of a frame -> outputs 0 immediately. A following 2-beat frame reports frame_len=2 and frame_count=1.
- stat_clear asserted in the same cycle as a tlast beat with frame_count=5 -> frame_len_valid strobes with the correct length; frame_count=0, len_min=all-ones, len_max=0.
